// File: rtl/aes_round_seq.sv
// AES round sequencer: accepts a block, pulses the datapath load, steps the
// round counter 0..Nr under key-schedule flow control and holds the result
// until the consumer takes it.
module aes_round_seq #(
  parameter bit STALL_EN = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   keysize,
  input  logic         dir,
  input  logic [127:0] in_data,
  input  logic         abort,
  input  logic         kx_valid,
  input  logic [127:0] dp_out,
  input  logic         out_ready,
  output logic         ready,
  output logic         err,
  output logic         dp_load,
  output logic [127:0] dp_in,
  output logic         dp_dir,
  output logic [3:0]   round,
  output logic         key_en,
  output logic         last,
  output logic         out_valid,
  output logic [127:0] out_data
);

  typedef enum logic [1:0] {StIdle, StLoad, StRound, StDone} state_e;

  state_e       state_q, state_d;
  logic [3:0]   round_q, round_d;
  logic [3:0]   nr_q, nr_d;
  logic         dir_q, dir_d;
  logic [127:0] din_q, din_d;
  logic [127:0] dout_q, dout_d;
  logic         err_q, err_d;
  logic         step;
  logic [3:0]   nr_req;

  // Round-key availability gates stepping only when stalls are enabled.
  assign step = STALL_EN ? kx_valid : 1'b1;

  // Final round index for the requested key size (reserved code never latched).
  always_comb begin
    nr_req = 4'd14;
    unique case (keysize)
      2'b00:   nr_req = 4'd10;
      2'b01:   nr_req = 4'd12;
      default: nr_req = 4'd14;
    endcase
  end

  // Next-state logic for the sequencer and its latched operands.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    nr_d    = nr_q;
    dir_d   = dir_q;
    din_d   = din_q;
    dout_d  = dout_q;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (keysize == 2'b11) begin
            err_d = 1'b1;
          end else begin
            nr_d    = nr_req;
            dir_d   = dir;
            din_d   = in_data;
            round_d = 4'd0;
            state_d = StLoad;
          end
        end
      end
      StLoad: begin
        if (abort) begin
          state_d = StIdle;
          round_d = 4'd0;
        end else begin
          state_d = StRound;
        end
      end
      StRound: begin
        // Abort takes priority over a simultaneous step.
        if (abort) begin
          state_d = StIdle;
          round_d = 4'd0;
        end else if (step) begin
          if (round_q == nr_q) begin
            dout_d  = dp_out;
            state_d = StDone;
          end else begin
            round_d = round_q + 4'd1;
          end
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
          round_d = 4'd0;
        end
      end
      default: begin
        state_d = StIdle;
        round_d = 4'd0;
      end
    endcase
  end

  // State and operand registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      round_q <= 4'd0;
      nr_q    <= 4'd10;
      dir_q   <= 1'b0;
      din_q   <= '0;
      dout_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      nr_q    <= nr_d;
      dir_q   <= dir_d;
      din_q   <= din_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
    end
  end

  // Outputs decoded from registered state; key_en alone sees inputs.
  assign ready     = (state_q == StIdle);
  assign dp_load   = (state_q == StLoad);
  assign key_en    = (state_q == StRound) && step && !abort;
  assign last      = (state_q == StRound) && (round_q == nr_q);
  assign out_valid = (state_q == StDone);
  assign err       = err_q;
  assign dp_in     = din_q;
  assign dp_dir    = dir_q;
  assign round     = round_q;
  assign out_data  = dout_q;

endmodule

// File: tb/tb_aes_round_seq.sv
// Scoreboard bench for aes_round_seq with a toy round datapath model.
module tb_aes_round_seq;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   keysize;
  logic         dir;
  logic [127:0] in_data;
  logic         abort;
  logic         kx_valid;
  logic [127:0] dp_out;
  logic         out_ready;
  logic         ready, err, dp_load, dp_dir, key_en, last, out_valid;
  logic [127:0] dp_in, out_data;
  logic [3:0]   round;

  aes_round_seq #(.STALL_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .keysize(keysize), .dir(dir),
    .in_data(in_data), .abort(abort), .kx_valid(kx_valid), .dp_out(dp_out),
    .out_ready(out_ready), .ready(ready), .err(err), .dp_load(dp_load),
    .dp_in(dp_in), .dp_dir(dp_dir), .round(round), .key_en(key_en), .last(last),
    .out_valid(out_valid), .out_data(out_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] data;
    int           lat;
  } exp_t;

  exp_t         sb[$];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           acc = 0;
  int           n_key, n_load, n_err, n_last, last_bad;
  logic [3:0]   nr_cur = 4'd10;
  logic [127:0] dp_q = '0;
  logic [127:0] cur_exp = '0;
  logic         vld_prev = 1'b0;

  // Toy round function: direction-dependent rotate and xor.
  function automatic logic [127:0] mix(input logic [127:0] x, input logic d);
    if (d) return {x[0], x[127:1]} ^ 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    return {x[126:0], x[127]} ^ 128'hdead_beef_0000_1111_2222_3333_4444_5555;
  endfunction

  // Value on dp_out when the final step is taken: Nr steps applied.
  function automatic logic [127:0] expf(input logic [127:0] x, input int nr, input logic d);
    logic [127:0] v = x;
    for (int i = 0; i < nr; i++) v = mix(v, d);
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic chkn(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL timeout_%s act=expired exp=event", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Datapath model driven by the sequencer's load/step strobes.
  always @(posedge clk) begin
    if (dp_load) dp_q <= dp_in;
    else if (key_en) dp_q <= mix(dp_q, dp_dir);
  end
  assign dp_out = dp_q;

  always @(posedge clk) cyc++;

  // Strobe counters and last-flag sanity.
  always @(negedge clk) begin
    if (reset) begin
      if (key_en) n_key++;
      if (dp_load) n_load++;
      if (err) n_err++;
      if (last) n_last++;
      if (last && (round != nr_cur || out_valid || dp_load)) last_bad++;
    end
  end

  // Monitor: pop on rising out_valid, then hold out_data stable while valid.
  always @(negedge clk) begin
    if (!reset) begin
      vld_prev = 1'b0;
    end else begin
      if (out_valid && !vld_prev) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out_valid act=1 exp=0");
        end else begin
          exp_t e;
          e = sb.pop_front();
          cur_exp = e.data;
          chk("out_data", out_data, e.data);
          chkn("latency", cyc - acc, e.lat);
        end
      end else if (out_valid) begin
        chk("out_data_stable", out_data, cur_exp);
      end
      vld_prev = out_valid;
    end
  end

  task automatic check_reset_outputs(input string tag);
    chkn({tag, "_ready"}, int'(ready), 1);
    chkn({tag, "_err"}, int'(err), 0);
    chkn({tag, "_dp_load"}, int'(dp_load), 0);
    chkn({tag, "_key_en"}, int'(key_en), 0);
    chkn({tag, "_last"}, int'(last), 0);
    chkn({tag, "_out_valid"}, int'(out_valid), 0);
    chkn({tag, "_round"}, int'(round), 0);
    chkn({tag, "_dp_dir"}, int'(dp_dir), 0);
    chk({tag, "_dp_in"}, dp_in, '0);
    chk({tag, "_out_data"}, out_data, '0);
  endtask

  // Issue one block from a post-edge point; checks the LOAD cycle.
  task automatic issue(input logic [1:0] ks, input logic d, input logic [127:0] data,
                       input bit expect_out, input int extra);
    n_key = 0; n_load = 0; n_err = 0; n_last = 0; last_bad = 0;
    nr_cur = (ks == 2'b00) ? 4'd10 : (ks == 2'b01) ? 4'd12 : 4'd14;
    if (expect_out) sb.push_back('{expf(data, int'(nr_cur), d), int'(nr_cur) + 2 + extra});
    start = 1'b1; keysize = ks; dir = d; in_data = data;
    tick();
    acc = cyc;
    start = 1'b0; in_data = ~data; dir = ~d; keysize = 2'b10;
    @(negedge clk);
    chkn("load_dp_load", int'(dp_load), 1);
    chkn("load_key_en", int'(key_en), 0);
    chk("load_dp_in", dp_in, data);
    chkn("load_dp_dir", int'(dp_dir), int'(d));
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!ready && n < 300) begin
      tick();
      n++;
    end
    if (!ready) timeout(name);
  endtask

  task automatic wait_round(input logic [3:0] r, input string name);
    int n = 0;
    while (round != r && n < 300) begin
      tick();
      n++;
    end
    if (round != r) timeout(name);
  endtask

  task automatic block_stats(input string tag, input int keys);
    chkn({tag, "_n_load"}, n_load, 1);
    chkn({tag, "_n_key"}, n_key, keys);
    chkn({tag, "_n_last"}, n_last, 1);
    chkn({tag, "_last_bad"}, last_bad, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    reset = 1'b0; start = 1'b0; keysize = 2'b00; dir = 1'b0; in_data = '0;
    abort = 1'b0; kx_valid = 1'b1; out_ready = 1'b1;
    #12;
    check_reset_outputs("por");
    tick();
    reset = 1'b1;

    // AES-128, accepted on the first edge after reset release.
    issue(2'b00, 1'b0, 128'h0011_2233_4455_6677_8899_aabb_ccdd_eeff, 1'b1, 0);
    wait_ready("aes128");
    block_stats("aes128", 11);

    // AES-256 decrypt with three stalled cycles at round 5.
    issue(2'b10, 1'b1, 128'h0f0e_0d0c_0b0a_0908_0706_0504_0302_0100, 1'b1, 3);
    wait_round(4'd5, "r5");
    kx_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chkn("stall_key_en", int'(key_en), 0);
      chkn("stall_round", int'(round), 5);
      @(posedge clk);
      #1;
    end
    kx_valid = 1'b1;
    wait_ready("aes256");
    block_stats("aes256", 15);

    // Reserved key size: one err pulse, nothing loaded.
    n_err = 0; n_load = 0;
    start = 1'b1; keysize = 2'b11;
    tick();
    start = 1'b0; keysize = 2'b00;
    @(negedge clk);
    chkn("rsv_err", int'(err), 1);
    chkn("rsv_ready", int'(ready), 1);
    tick();
    @(negedge clk);
    chkn("rsv_err_clear", int'(err), 0);
    tick();
    chkn("rsv_n_err", n_err, 1);
    chkn("rsv_n_load", n_load, 0);

    // AES-192 with back-pressure; start during DONE must be ignored.
    out_ready = 1'b0;
    issue(2'b01, 1'b0, 128'hcafe_f00d_1234_5678_9abc_def0_0bad_beef, 1'b1, 0);
    begin
      int n = 0;
      while (!out_valid && n < 100) begin
        tick();
        n++;
      end
      if (!out_valid) timeout("aes192_valid");
    end
    for (int i = 0; i < 4; i++) begin
      start = 1'b1; keysize = 2'b00;
      @(negedge clk);
      chkn("bp_out_valid", int'(out_valid), 1);
      chkn("bp_ready", int'(ready), 0);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chkn("bp_ready_same_cycle", int'(ready), 0);
    tick();
    @(negedge clk);
    chkn("bp_ready_after", int'(ready), 1);
    tick();
    block_stats("aes192", 13);
    chkn("bp_n_err", n_err, 0);

    // Abort at round 3: no step that cycle, back to idle, no output.
    issue(2'b00, 1'b0, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 1'b0, 0);
    wait_round(4'd3, "r3");
    abort = 1'b1;
    @(negedge clk);
    chkn("abort_key_en", int'(key_en), 0);
    tick();
    abort = 1'b0;
    @(negedge clk);
    chkn("abort_ready", int'(ready), 1);
    chkn("abort_round", int'(round), 0);
    chkn("abort_out_valid", int'(out_valid), 0);
    chkn("abort_n_key", n_key, 3);
    tick();
    issue(2'b00, 1'b1, 128'h8888_7777_6666_5555_4444_3333_2222_1111, 1'b1, 0);
    wait_ready("post_abort");
    block_stats("post_abort", 11);

    // Reset mid-block at round 7, then a fresh AES-128 block.
    issue(2'b10, 1'b0, 128'h5a5a_5a5a_a5a5_a5a5_5a5a_5a5a_a5a5_a5a5, 1'b0, 0);
    wait_round(4'd7, "r7");
    reset = 1'b0;
    #1;
    check_reset_outputs("midrst");
    tick();
    tick();
    reset = 1'b1;
    issue(2'b00, 1'b0, 128'h0123_4567_89ab_cdef_0123_4567_89ab_cdef, 1'b1, 0);
    wait_ready("post_reset");
    block_stats("post_reset", 11);

    tick();
    chkn("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
